// File: rtl/pwm_actuator.sv
// pwm_actuator: turns an 8-bit duty word into a complementary half-bridge
// gate-drive pair with dead-time insertion. Duty updates arrive via a
// valid/ready handshake into a shadow register and are applied only at a
// period boundary, so every PWM period is glitch-free.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | disabled, both gate drives low
// HI    | high-side on (pwm_hi=1)
// LO    | low-side on (pwm_lo=1)
// DT    | dead window, both low, dt_cnt counts down to the exit cycle
module pwm_actuator #(
  parameter int unsigned DIV       = 1,
  parameter int unsigned DEAD_TIME = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] duty_in,
  input  logic       duty_valid,
  output logic       duty_ready,
  output logic       pwm_hi,
  output logic       pwm_lo,
  output logic       period_start,
  output logic [7:0] duty_active
);

  localparam logic [15:0] PRESC_MAX = 16'(DIV - 1);
  localparam bit          NO_DT     = (DEAD_TIME == 0);
  localparam logic [3:0]  DT_LAST   = NO_DT ? 4'd0 : 4'(DEAD_TIME - 1);

  typedef enum logic [1:0] {S_IDLE, S_HI, S_LO, S_DT} state_t;

  logic [15:0] presc;
  logic [7:0]  cnt;
  logic        en_q;
  logic        tick;
  logic        load_pt;
  logic        handshake;
  logic [7:0]  shadow;
  logic        shadow_full;
  logic        raw_q;
  state_t      state;
  logic [3:0]  dt_cnt;
  logic        switch_req;

  assign tick       = (presc == PRESC_MAX);
  // en_q low marks the first enabled cycle, which also counts as a load point
  assign load_pt    = enable && ((tick && (cnt == 8'hFF)) || !en_q);
  assign duty_ready = ~shadow_full;
  assign handshake  = duty_valid && duty_ready;

  // Prescaler and period counter; both held at zero while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      cnt   <= '0;
      en_q  <= 1'b0;
    end else begin
      en_q <= enable;
      if (!enable) begin
        presc <= '0;
        cnt   <= '0;
      end else if (tick) begin
        presc <= '0;
        cnt   <= cnt + 8'd1;
      end else begin
        presc <= presc + 16'd1;
      end
    end
  end

  // Shadow register fill and transfer to the active duty at load points
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow      <= '0;
      shadow_full <= 1'b0;
      duty_active <= '0;
    end else if (handshake) begin
      // only possible while empty, so it never collides with a transfer
      shadow      <= duty_in;
      shadow_full <= 1'b1;
    end else if (load_pt && shadow_full) begin
      duty_active <= shadow;
      shadow_full <= 1'b0;
    end
  end

  // Registered compare and period strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q        <= 1'b0;
      period_start <= 1'b0;
    end else begin
      raw_q        <= (cnt < duty_active);
      period_start <= load_pt;
    end
  end

  // Decide whether the current drive state disagrees with the compare
  always_comb begin
    switch_req = 1'b0;
    unique case (state)
      S_IDLE:  switch_req = 1'b1;
      S_HI:    switch_req = !raw_q;
      S_LO:    switch_req = raw_q;
      default: switch_req = 1'b0;
    endcase
  end

  // Gate-drive FSM with dead-time insertion and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      dt_cnt <= '0;
      pwm_hi <= 1'b0;
      pwm_lo <= 1'b0;
    end else if (!enable) begin
      state  <= S_IDLE;
      dt_cnt <= '0;
      pwm_hi <= 1'b0;
      pwm_lo <= 1'b0;
    end else if ((state == S_DT && dt_cnt == 4'd0) || (switch_req && NO_DT)) begin
      // only the compare value at exit matters, edges inside DT are ignored
      state  <= raw_q ? S_HI : S_LO;
      pwm_hi <= raw_q;
      pwm_lo <= !raw_q;
    end else if (switch_req) begin
      state  <= S_DT;
      dt_cnt <= DT_LAST;
      pwm_hi <= 1'b0;
      pwm_lo <= 1'b0;
    end else if (state == S_DT) begin
      dt_cnt <= dt_cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_pwm_actuator.sv
// Bench for pwm_actuator: directed scenarios followed by randomized traffic,
// every cycle compared against a behavioural model of the drive stage.
module tb_pwm_actuator;

  localparam int DIV = 1;
  localparam int DT  = 2;
  localparam int PER = 256 * DIV;
  localparam int SIDE_OFF = 0, SIDE_HI = 1, SIDE_LO = 2, SIDE_DEAD = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       duty_valid = 1'b0;
  logic [7:0] duty_in = 8'd0;
  logic       duty_ready, pwm_hi, pwm_lo, period_start;
  logic [7:0] duty_active;

  int checks = 0;
  int failures = 0;

  // model state: cycles since enable rose, shadow/active duty, compare, drive side
  int m_cyc, m_shadow, m_duty, m_side, m_dead;
  bit m_en_prev, m_full, m_raw, m_ps;

  pwm_actuator #(.DIV(DIV), .DEAD_TIME(DT)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .duty_in(duty_in),
    .duty_valid(duty_valid), .duty_ready(duty_ready), .pwm_hi(pwm_hi),
    .pwm_lo(pwm_lo), .period_start(period_start), .duty_active(duty_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0; m_shadow = 0; m_duty = 0; m_side = SIDE_OFF; m_dead = 0;
    m_en_prev = 0; m_full = 0; m_raw = 0; m_ps = 0;
  endtask

  // advance the model across one clock edge using the inputs presented now
  task automatic model_step();
    int cyc_en, cnt_now, want;
    bit load, hs, n_raw;
    if (!rst_n) begin
      model_reset();
      return;
    end
    cyc_en  = m_en_prev ? m_cyc + 1 : 0;
    cnt_now = (cyc_en / DIV) % 256;
    load    = enable && (!m_en_prev || (cyc_en % PER) == PER - 1);
    hs      = duty_valid && !m_full;
    n_raw   = (cnt_now < m_duty);
    if (hs) begin
      m_shadow = int'(duty_in);
      m_full = 1;
    end else if (load && m_full) begin
      m_duty = m_shadow;
      m_full = 0;
    end
    if (!enable) begin
      m_side = SIDE_OFF;
      m_dead = 0;
    end else begin
      want = m_raw ? SIDE_HI : SIDE_LO;
      if (m_side == SIDE_DEAD) begin
        m_dead--;
        if (m_dead == 0) m_side = want;
      end else if (m_side != want) begin
        if (DT == 0) m_side = want;
        else begin
          m_side = SIDE_DEAD;
          m_dead = DT;
        end
      end
    end
    m_raw = n_raw;
    m_ps = load;
    m_en_prev = enable;
    if (enable) m_cyc = cyc_en;
  endtask

  task automatic compare_all();
    chk("pwm_hi", pwm_hi, (m_side == SIDE_HI));
    chk("pwm_lo", pwm_lo, (m_side == SIDE_LO));
    chk("period_start", period_start, m_ps);
    chk("duty_active", duty_active, m_duty);
    chk("duty_ready", duty_ready, !m_full);
    chk("no_overlap", (pwm_hi & pwm_lo), 0);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic wait_pstart();
    bit found = 0;
    for (int i = 0; i < PER + 50; i++) begin
      cycle();
      if (period_start === 1'b1) begin
        found = 1;
        break;
      end
    end
    chk("wait_period_start", found, 1);
  endtask

  task automatic wait_hi();
    bit found = 0;
    for (int i = 0; i < PER + 50; i++) begin
      if (pwm_hi === 1'b1) begin
        found = 1;
        break;
      end
      cycle();
    end
    chk("wait_pwm_hi", found, 1);
  endtask

  task automatic push(input int val);
    duty_valid = 1'b1;
    duty_in = 8'(val);
    cycle();
    duty_valid = 1'b0;
  endtask

  // count drive levels over one full period window in steady state
  task automatic measure(input string tag, input int duty);
    int hi_n = 0, lo_n = 0, dead_n = 0, ps_n = 0;
    int exp_hi, exp_lo, exp_dead;
    for (int i = 0; i < PER; i++) begin
      cycle();
      if (pwm_hi === 1'b1) hi_n++;
      if (pwm_lo === 1'b1) lo_n++;
      if (pwm_hi === 1'b0 && pwm_lo === 1'b0) dead_n++;
      if (period_start === 1'b1) ps_n++;
    end
    if (duty == 0) begin
      exp_hi = 0; exp_lo = PER; exp_dead = 0;
    end else if (duty == 255) begin
      exp_hi = PER - DT; exp_lo = 0; exp_dead = DT;
    end else begin
      exp_hi = duty - DT; exp_lo = PER - duty - DT; exp_dead = 2 * DT;
    end
    chk({tag, "_hi_cycles"}, hi_n, exp_hi);
    chk({tag, "_lo_cycles"}, lo_n, exp_lo);
    chk({tag, "_dead_cycles"}, dead_n, exp_dead);
    chk({tag, "_period_starts"}, ps_n, 1);
  endtask

  initial begin
    int seq[$];
    int off_left;
    bit pre_hs;
    model_reset();

    // reset held with enable high and duty_valid toggling
    rst_n = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      duty_valid = i[0];
      duty_in = 8'(i * 37);
      cycle();
      chk("rst_duty_ready", duty_ready, 1);
      chk("rst_duty_active", duty_active, 0);
      chk("rst_pwm", {pwm_hi, pwm_lo, period_start}, 0);
    end
    duty_valid = 1'b0;
    rst_n = 1'b1;

    // duty 64, accepted in the very first enabled cycle
    push(64);
    cycle();
    chk("held_ready_low", duty_ready, 0);
    wait_pstart();
    chk("duty64_applied", duty_active, 64);
    cycle();
    chk("ready_after_load", duty_ready, 1);
    wait_pstart();
    measure("duty64", 64);

    push(0);
    wait_pstart();
    wait_pstart();
    measure("duty0", 0);

    push(255);
    wait_pstart();
    wait_pstart();
    measure("duty255", 255);

    // back-to-back updates: 200 held off until 100 has been applied
    push(100);
    chk("shadow_full_ready", duty_ready, 0);
    duty_valid = 1'b1;
    duty_in = 8'd200;
    for (int i = 0; i < 3 * PER && seq.size() < 2; i++) begin
      pre_hs = duty_valid && duty_ready;
      cycle();
      if (pre_hs) duty_valid = 1'b0;
      if (period_start === 1'b1) seq.push_back(int'(duty_active));
    end
    duty_valid = 1'b0;
    chk("load_count", seq.size(), 2);
    if (seq.size() == 2) begin
      chk("load_first", seq[0], 100);
      chk("load_second", seq[1], 200);
    end

    // enable drop while the high side is on, then re-enable
    wait_hi();
    enable = 1'b0;
    cycle();
    chk("dis_outputs", {pwm_hi, pwm_lo}, 0);
    chk("dis_cnt", dut.cnt, 0);
    repeat (3) cycle();
    enable = 1'b1;
    cycle();
    chk("reen_pstart", period_start, 1);
    chk("reen_dead0", {pwm_hi, pwm_lo}, 0);
    cycle();
    chk("reen_dead1", {pwm_hi, pwm_lo}, 0);
    cycle();
    chk("reen_hi", {pwm_hi, pwm_lo}, 2'b10);

    // asynchronous reset between clock edges
    wait_hi();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_hi", pwm_hi, 0);
    chk("async_lo", pwm_lo, 0);
    chk("async_duty", duty_active, 0);
    chk("async_ready", duty_ready, 1);
    chk("async_pstart", period_start, 0);
    model_reset();
    repeat (3) cycle();
    rst_n = 1'b1;

    // randomized traffic with occasional enable drops
    off_left = 0;
    for (int i = 0; i < 8000; i++) begin
      if (off_left > 0) begin
        off_left--;
        enable = (off_left == 0);
      end else if ($urandom_range(0, 599) == 0) begin
        enable = 1'b0;
        off_left = $urandom_range(1, 20);
      end
      duty_valid = ($urandom_range(0, 3) == 0);
      duty_in = 8'($urandom_range(0, 255));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
